// File: rtl/float2int_seq.sv
// Sequential expander for the 7-bit mini-float (3-bit exponent, 4-bit mantissa)
// into an 11-bit unsigned integer. It uses a one-bit-per-cycle shifter with valid/ready on both sides.
module float2int_seq #(
    parameter bit FILL_HALF = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_exp,
    input  logic [3:0]  in_man,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_data,
    output logic        out_exact,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [10:0] acc;
    logic [2:0]  cnt;
    logic [2:0]  exp_q;
    logic        exact;
    logic        accept;
    logic [10:0] half_ulp;
    logic [10:0] final_val;

    // A new word may enter while the previous result is being handed off.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);

    // Re-centring offset for the bits the encoder truncated.
    always_comb begin
        half_ulp = '0;
        if (FILL_HALF && (exp_q >= 3'd2)) begin
            half_ulp = 11'd1 << (exp_q - 3'd2);
        end
    end

    assign final_val = acc + half_ulp;

    // NOTE: every register below uses <= so all updates see pre-edge values;
    // a blocking = here would make the order of statements change the hardware.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            exp_q     <= '0;
            exact     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_exact <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != 3'd0) begin
                        acc <= {acc[9:0], 1'b0};
                        cnt <= cnt - 3'd1;
                    end else begin
                        acc       <= final_val;
                        out_data  <= final_val;
                        out_exact <= exact;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                IDLE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Loading overrides the DONE->IDLE move, giving back-to-back operation.
            if (accept) begin
                acc   <= (in_exp == 3'd0) ? {7'b0, in_man} : {6'b0, 1'b1, in_man};
                cnt   <= (in_exp == 3'd0) ? 3'd0 : in_exp - 3'd1;
                exp_q <= in_exp;
                exact <= (in_exp <= 3'd1);
                state <= SHIFT;
            end
        end
    end

endmodule

// File: doc/float2int_seq.md
Name: float2int_seq

Overview:
- Sequential decoder for the packed 7-bit mini-float format: 3-bit exponent, 4-bit mantissa.
- Expands each float to an 11-bit unsigned integer.
- This is the expander behind the int2float encoder. It restores magnitudes from the compressed form for downstream datapath logic.
- Valid/ready on both sides. A one-bit-per-cycle shifter keeps area minimal.

Parameters:
- FILL_HALF, 0: when 1, add half-ULP (1 << (e-2)) for e >= 2 to re-centre truncated values. When 0, truncated bits are zero.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  float word valid
- in_ready  out  1  decoder can accept a word this cycle
- in_exp  in  3  exponent e
- in_man  in  4  mantissa m
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  11  decoded integer
- out_exact  out  1  result is bit-exact (e <= 1, no truncated bits)
- busy  out  1  state != IDLE

Behaviour:
- Format, as fixed by the encoder:
  - e = 0: value = m (0..15).
  - e = 1..7: value = {1'b1, m} << (e-1).
  - Maximum value is 1984, or 2016 with FILL_HALF=1. Never exceeds 11 bits, so there is no overflow path.
- Reset (rst_n low at a clk edge): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_exact=0, busy=0. Reset wins over every other event, including mid-shift and a pending output (the pending output is dropped).
- State registers: acc[10:0], cnt[2:0], exact, state in {IDLE, SHIFT, DONE}.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational; no dependency on in_valid.
- Accept = in_valid & in_ready. On accept:
  - acc = (e==0) ? {7'b0, m} : {6'b0, 1'b1, m}
  - cnt = (e==0) ? 0 : e-1
  - exact = (e <= 1)
  - state -> SHIFT
- SHIFT:
  - If cnt != 0: acc <= acc << 1, cnt <= cnt - 1. The shifted-in bit is 0.
  - If cnt == 0: acc <= acc + half-ULP (only when FILL_HALF=1 and captured e >= 2; e is stored in a 3-bit reg), state -> DONE.
  - in_ready=0 throughout SHIFT.
- DONE:
  - out_valid=1; out_data=acc and out_exact=exact, both held stable while out_ready=0.
  - out_ready=1 with in_valid=0: state -> IDLE, out_valid falls next cycle.
  - out_ready=1 with in_valid=1: back-to-back; the new word loads and state -> SHIFT in the same edge.
- Latency: accept edge to out_valid high is 2 + (e==0 ? 0 : e-1) edges, i.e. 2..8.
- Throughput:
  - Back-to-back, one word per 2+cnt cycles.
  - With out_ready tied high, no idle bubble beyond the DONE cycle.
- out_data is only meaningful while out_valid=1. It retains the last value otherwise; do not clear it on handshake.
- in_exp/in_man are sampled only on the accept edge. Changes during SHIFT/DONE are ignored.
- Protocol assertions for the bench:
  - Once out_valid=1 it stays 1, with stable data, until out_ready.
  - in_ready never high in SHIFT.
  - busy == (state != IDLE).

Test Plan:
- Reset/idle: hold rst_n=0 3 cycles, then release. Required: out_valid=0, out_data=0, in_ready=1, busy=0.
- Sweep all 128 codes, FILL_HALF=0, out_ready=1. Required:
  - e=0, m=9 -> 9, exact=1, latency 2.
  - e=1, m=3 -> 19, exact=1.
  - e=5, m=10 -> 416, latency 6.
  - e=7, m=15 -> 1984, latency 8.
  - All 128 codes match the reference formula.
- FILL_HALF=1. Required:
  - e=5, m=10 -> 424.
  - e=7, m=15 -> 2016.
  - e=1, m=3 -> 19 (no fill).
  - e=0, m=0 -> 0.
- Backpressure: e=3, m=1 with out_ready=0 for 10 cycles. Required: out_valid=1 and out_data=68 stable throughout, in_ready=0. Then out_ready=1 for one cycle, after which out_valid drops.
- Back-to-back: in_valid held high with words (e=2, m=0) then (e=0, m=5), out_ready=1. Required: outputs 32 then 5. The second word is accepted on the same edge as the first output handshake.
- Reset mid-operation: accept e=7, m=1, assert rst_n=0 at the third SHIFT cycle. Required: next cycle out_valid=0, state IDLE, and no output for that word ever appears.
